// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: opcode and FSM state encodings,
// plus the per-opcode carry-in used to seed a frame.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_PASSA = 3'd5,
        OP_PASSB = 3'd6,
        OP_RSVD  = 3'd7
    } op_t;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    function automatic logic op_carry_in(op_t op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_bit_slice.sv
// One bit of the serial ALU: full adder for ADD/SUB plus the logic-op mux.
// Only the arithmetic ops produce a carry; everything else reports 0.
import serial_alu_pkg::*;

module serial_alu_bit_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  op_t  op,
    output logic r,
    output logic cout
);

    logic bx;

    always_comb begin
        bx   = (op == OP_SUB) ? ~b : b;
        r    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r    = a ^ bx ^ cin;
                cout = (a & bx) | (cin & (a ^ bx));
            end
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_responder.sv
// Bit-serial ALU: consumes N-bit operands LSB-first, returns the result
// LSB-first one cycle later, with carry/zero flags on the final bit.
import serial_alu_pkg::*;

module serial_alu_responder #(
    parameter int unsigned N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       r_bit,
    output logic       r_valid,
    output logic       done,
    output logic       cout,
    output logic       zero
);

    localparam int unsigned CW = $clog2(N);

    state_t        state;
    logic [CW-1:0] cnt;
    op_t           op_q;
    logic          carry;
    logic          zacc;

    logic start, step, active, last;
    op_t  cur_op;
    logic cin, zin;
    logic r_s, c_s;

    // Bit 0 is processed in the IDLE cycle itself, so the slice is fed from
    // the live opcode and a fresh carry-in/zero seed rather than the registers.
    always_comb begin
        start  = (state == S_IDLE) && en;
        step   = (state == S_RUN) && en;
        active = start || step;
        last   = step && (cnt == CW'(N - 1));
        cur_op = start ? op_t'(op) : op_q;
        cin    = start ? op_carry_in(op_t'(op)) : carry;
        zin    = start ? 1'b1 : zacc;
    end

    serial_alu_bit_slice u_slice (
        .a    (a_bit),
        .b    (b_bit),
        .cin  (cin),
        .op   (cur_op),
        .r    (r_s),
        .cout (c_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            op_q    <= OP_ADD;
            carry   <= 1'b0;
            zacc    <= 1'b1;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            done    <= 1'b0;
            cout    <= 1'b0;
            zero    <= 1'b0;
        end else begin
            r_bit   <= active & r_s;
            r_valid <= active;
            done    <= last;
            cout    <= last & c_s;
            zero    <= last & zin & ~r_s;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        op_q  <= op_t'(op);
                        cnt   <= CW'(1);
                        carry <= c_s;
                        zacc  <= ~r_s;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!en || last) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        carry <= 1'b0;
                        zacc  <= 1'b1;
                    end else begin
                        cnt   <= cnt + CW'(1);
                        carry <= c_s;
                        zacc  <= zin & ~r_s;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_responder.sv
// Bench for serial_alu_responder: word-level reference model predicts every
// output cycle; directed frames are pinned to hand-computed literals.
module tb_serial_alu_responder;

    localparam int unsigned N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic       a_bit, b_bit;
    logic       r_bit, r_valid, done, cout, zero;

    serial_alu_responder #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op      (op),
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .r_bit   (r_bit),
        .r_valid (r_valid),
        .done    (done),
        .cout    (cout),
        .zero    (zero)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // expected outputs after the next rising edge
    logic e_r = 1'b0, e_v = 1'b0, e_d = 1'b0, e_c = 1'b0, e_z = 1'b0;

    logic [N-1:0] acc = '0;
    int           idx = 0;
    logic [N-1:0] cap_res = '0;
    logic         cap_c = 1'b0, cap_z = 1'b0;
    int           done_cnt = 0;
    int           cyc = 0;
    int           done_cyc[$];
    logic [N-1:0] res_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp_v, $time);
        end
    endtask

    function automatic void model(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] res, output logic c);
        logic [N:0] s;
        case (o)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
            3'd2:    s = {1'b0, a & b};
            3'd3:    s = {1'b0, a | b};
            3'd4:    s = {1'b0, a ^ b};
            3'd5:    s = {1'b0, a};
            3'd6:    s = {1'b0, b};
            default: s = '0;
        endcase
        res = s[N-1:0];
        c   = (o <= 3'd1) ? s[N] : 1'b0;
    endfunction

    // Per-cycle compare against the model, plus stream reassembly for literal pins.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            check("r_bit",   32'(r_bit),   32'(e_r));
            check("r_valid", 32'(r_valid), 32'(e_v));
            check("done",    32'(done),    32'(e_d));
            check("cout",    32'(cout),    32'(e_c));
            check("zero",    32'(zero),    32'(e_z));
            if (r_valid) begin
                if (idx < int'(N)) acc[idx] = r_bit;
                idx++;
            end else begin
                idx = 0;
            end
            if (done) begin
                cap_res = acc;
                cap_c   = cout;
                cap_z   = zero;
                done_cnt++;
                done_cyc.push_back(cyc);
                res_q.push_back(acc);
                idx = 0;
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en    = 1'b0;
            op    = 3'($urandom);
            a_bit = 1'($urandom);
            b_bit = 1'($urandom);
            e_r = 1'b0; e_v = 1'b0; e_d = 1'b0; e_c = 1'b0; e_z = 1'b0;
        end
    endtask

    task automatic frame(input logic [2:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int nb, input bit toggle);
        logic [N-1:0] res;
        logic         c;
        model(o, a, b, res, c);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            en    = 1'b1;
            op    = (i == 0 || !toggle) ? o : 3'($urandom);
            a_bit = a[i];
            b_bit = b[i];
            e_r   = res[i];
            e_v   = 1'b1;
            e_d   = (i == int'(N) - 1);
            e_c   = (i == int'(N) - 1) ? c : 1'b0;
            e_z   = (i == int'(N) - 1) ? (res == '0) : 1'b0;
        end
    endtask

    task automatic pin(input string name, input logic [N-1:0] r, input logic c, input logic z);
        check({name, "_res"},  32'(cap_res), 32'(r));
        check({name, "_cout"}, 32'(cap_c),   32'(c));
        check({name, "_zero"}, 32'(cap_z),   32'(z));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int d0;
        rst = 1'b1; en = 1'b0; op = 3'd0; a_bit = 1'b0; b_bit = 1'b0;
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        frame(3'd0, 8'h5A, 8'hC3, N, 1'b0); idle(1);
        pin("add_5a_c3", 8'h1D, 1'b1, 1'b0);
        frame(3'd1, 8'h10, 8'h10, N, 1'b0); idle(1);
        pin("sub_10_10", 8'h00, 1'b1, 1'b1);
        frame(3'd1, 8'h03, 8'h05, N, 1'b0); idle(1);
        pin("sub_03_05", 8'hFE, 1'b0, 1'b0);
        frame(3'd4, 8'hFF, 8'h0F, N, 1'b1); idle(1);
        pin("xor_ff_0f", 8'hF0, 1'b0, 1'b0);
        frame(3'd7, 8'hAA, 8'h55, N, 1'b1); idle(1);
        pin("rsvd_aa_55", 8'h00, 1'b0, 1'b1);

        // back-to-back frames with en held high
        d0 = done_cnt;
        frame(3'd0, 8'h01, 8'h01, N, 1'b0);
        frame(3'd2, 8'hF0, 8'h3C, N, 1'b0);
        idle(1);
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_res0", 32'(res_q[res_q.size()-2]), 32'h02);
        check("b2b_res1", 32'(res_q[res_q.size()-1]), 32'h30);
        check("b2b_spacing", 32'(done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2]), 32'd8);

        // abort after 3 bits
        d0 = done_cnt;
        frame(3'd0, 8'($urandom), 8'($urandom), 3, 1'b0);
        idle(2);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        frame(3'd0, 8'h7F, 8'h01, N, 1'b0); idle(1);
        pin("add_7f_01", 8'h80, 1'b0, 1'b0);

        // async reset between clock edges, mid-frame
        frame(3'd0, 8'($urandom), 8'($urandom), 4, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_r_bit",   32'(r_bit),   32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_cout",    32'(cout),    32'd0);
        check("rst_zero",    32'(zero),    32'd0);
        idle(1);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        frame(3'd0, 8'hFF, 8'h01, N, 1'b0); idle(1);
        pin("add_ff_01", 8'h00, 1'b1, 1'b1);

        // randomized traffic: mixed ops, gaps, back-to-back, aborts, mid-frame op noise
        for (int k = 0; k < 60; k++) begin
            logic [2:0]   o;
            logic [N-1:0] a, b;
            o = 3'($urandom);
            a = N'($urandom);
            b = N'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                frame(o, a, b, int'($urandom_range(1, N - 1)), 1'($urandom));
                idle(int'($urandom_range(1, 2)));
            end else begin
                frame(o, a, b, N, 1'($urandom));
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(2);
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
